serial_subtractor_16b: RTL
==========================

Name: serial_subtractor_16b

Overview:
- Multi-cycle digit-serial subtractor: computes DIFF = A - B - bin one DIGIT-wide slice per clock, LSB slice first.
- Borrow/carry is held in a flop between slices.
- Inverse-operation companion to the ripple adders in the ALU datapath.
- Valid/ready handshake on both sides; sits between operand fetch and writeback, where area matters more than latency.

Parameters:
- WIDTH, 16, operand and result width; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per cycle; STEPS = WIDTH/DIGIT (default 4).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  minuend
- b  input  WIDTH  subtrahend
- bin  input  1  borrow in
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- diff  output  WIDTH  a - b - bin, modulo 2^WIDTH
- bout  output  1  borrow out; 1 when unsigned a < b + bin
- ovf  output  1  signed two's-complement overflow
- zero  output  1  diff == 0

Behaviour:
- States: IDLE, BUSY, DONE.
  - Reset (async, rst_n low): state = IDLE; in_ready = 1; out_valid = 0; diff = 0; bout = 0; ovf = 0; zero = 0; step counter = 0; carry flop = 0.
- IDLE:
  - in_ready = 1.
  - Accept on the edge where in_valid && in_ready: latch a, b into shift registers; carry flop <= ~bin; counter <= 0; go to BUSY.
- BUSY:
  - in_ready = 0; in_valid is ignored.
  - Each edge processes slice k = counter: {c, d} = a_slice + ~b_slice + carry; d is written into diff[k*DIGIT +: DIGIT]; carry <= c; counter++.
  - After slice STEPS-1 is processed, go to DONE.
  - Final-edge assignments: bout = ~carry_final; ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]); zero = (full diff == 0).
- DONE:
  - out_valid = 1; diff, bout, ovf and zero are stable and held.
  - in_ready = 0.
  - On the edge where out_ready == 1: out_valid <= 0; go to IDLE.
  - No same-cycle re-accept; the next operand pair is accepted no earlier than the following edge.
- Latency: accept edge T; out_valid is high in the cycle after edge T + STEPS (4 edges for default).
  - Throughput: one result per STEPS + 2 cycles when out_ready is held high.
- Backpressure: with out_ready low, state stays DONE indefinitely and all outputs are held unchanged.
- Outputs while out_valid = 0:
  - diff holds its last value, or partial-slice contents during BUSY.
  - Consumers must sample only when out_valid = 1.
- Reset mid-operation (BUSY or DONE): immediate return to reset values; the in-flight result is discarded.
- Wrap-around: diff is modulo 2^WIDTH. ovf is independent of bin's effect on sign, except through diff[W-1] as computed.
- Counter width: ceil(log2(STEPS)); it must not overflow at STEPS = 4.

Test Plan:
- Reset, then a=0x1234, b=0x0234, bin=0, out_ready=1 -> after 4 BUSY edges: out_valid=1, diff=0x1000, bout=0, ovf=0, zero=0; in_ready returns 1 the following cycle.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0, zero=0. Then a=0x8000, b=0x0001 -> diff=0x7FFF, bout=0, ovf=1.
- a=0x0010, b=0x000F, bin=1 -> diff=0x0000, zero=1, bout=0. Then a=0x5555, b=0x5555, bin=0 -> diff=0x0000, zero=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, diff unchanged, in_ready=0. Toggle in_valid with new operands during BUSY/DONE -> ignored, result unchanged.
- Reset mid-op: drop rst_n during BUSY step 2 -> outputs return asynchronously to reset values; after release, a fresh a=0x0003, b=0x0005 -> diff=0xFFFE, bout=1.
- Back-to-back: in_valid held high with out_ready=1 across 3 operand pairs -> each accepted exactly once, results in order, spacing STEPS+2 cycles.

Source files
------------

// File: rtl/serial_subtractor_16b.sv
// -----------------------------------------------------------------------------
// serial_subtractor_16b
//
// Digit-serial subtractor: computes diff = a - b - bin one DIGIT-wide slice per
// clock, least-significant slice first. The borrow travels between slices in a
// single carry flop (held as an inverted borrow, i.e. a + ~b + carry).
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid
//   in_ready   block can accept operands (high only in IDLE)
//   a, b       minuend / subtrahend (WIDTH bits)
//   bin        borrow in
//   out_valid  result valid (high only in DONE)
//   out_ready  consumer accepts result
//   diff       a - b - bin, modulo 2^WIDTH
//   bout       borrow out: 1 when unsigned a < b + bin
//   ovf        signed two's-complement overflow
//   zero       diff == 0
// -----------------------------------------------------------------------------
module serial_subtractor_16b #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t          state;
  state_t          state_next;

  // Operands shift right by DIGIT each step, so the active slice is always
  // the low DIGIT bits; on the last step it holds the operand sign bits.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry;      // inverted borrow between slices
  logic [CW-1:0]    cnt;        // index of the slice processed on the next edge
  logic [DIGIT:0]   slice_sum;  // {carry out, slice result}
  logic [WIDTH-1:0] diff_full;  // diff with the current slice merged in
  logic             last_step;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign last_step = (cnt == LAST);

  always_comb begin
    slice_sum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, ~b_sh[DIGIT-1:0]}
              + {{DIGIT{1'b0}}, carry};
  end

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    diff_full                     = diff;
    diff_full[cnt*DIGIT +: DIGIT] = slice_sum[DIGIT-1:0];
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (in_valid)  state_next = BUSY;
      BUSY:    if (last_step) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: the operand shift registers are reset along with the rest even
  // though their contents are don't-care in IDLE; it keeps the reset state of
  // the whole block deterministic at negligible cost for 2*WIDTH flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      diff  <= '0;
      bout  <= 1'b0;
      ovf   <= 1'b0;
      zero  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= ~bin;  // a - b - bin == a + ~b + ~bin
            cnt   <= '0;
          end
        end
        BUSY: begin
          diff  <= diff_full;
          carry <= slice_sum[DIGIT];
          a_sh  <= a_sh >> DIGIT;
          b_sh  <= b_sh >> DIGIT;
          cnt   <= last_step ? '0 : cnt + 1'b1;
          if (last_step) begin
            bout <= ~slice_sum[DIGIT];
            // Overflow only when the operand signs differ and the result sign
            // departs from the minuend's sign.
            ovf  <= (a_sh[DIGIT-1] ^ b_sh[DIGIT-1])
                  & (slice_sum[DIGIT-1] ^ a_sh[DIGIT-1]);
            zero <= ~|diff_full;
          end
        end
        default: ;  // DONE: results held until the consumer takes them
      endcase
    end
  end

endmodule
